// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer so words stream
// back-to-back; bit rate is paced by the in_enable strobe.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_write,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_enable,
    output logic             out_bit,
    output logic             out_busy,
    output logic             out_full,
    output logic             out_last,
    output logic             out_overflow
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             overflow_q, overflow_d;
    logic             at_last;
    logic             drain;
    logic             accept;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sh_q         <= '0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        overflow_d   = overflow_q;

        at_last = (state_q == StShift) && in_enable && (cnt_q == LastCnt);
        // The buffer empties into the shifter when idle, or on the final enabled bit.
        drain   = hold_valid_q && ((state_q == StIdle) || at_last);
        accept  = in_write && (!hold_valid_q || drain);

        if (in_write) begin
            if (accept) begin
                hold_d       = in_data;
                hold_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (drain) begin
            sh_d    = hold_q;
            cnt_d   = '0;
            state_d = StShift;
            if (!accept) begin
                hold_valid_d = 1'b0;
            end
        end else if (state_q == StShift && in_enable) begin
            if (cnt_q == LastCnt) begin
                state_d = StIdle;
            end else begin
                sh_d  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        out_busy     = (state_q == StShift);
        out_full     = hold_valid_q;
        out_bit      = out_busy && (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]);
        out_last     = out_busy && (cnt_q == LastCnt);
        out_overflow = overflow_q;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an 8-bit MSB-first and a 12-bit LSB-first instance
// share clock, reset and enable; expected bits are queued at write time and popped per bit.
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr8, wr12, en;
    logic [7:0]  d8;
    logic [11:0] d12;
    logic        bit8, busy8, full8, last8, ovf8;
    logic        bit12, busy12, full12, last12, ovf12;

    int   errors = 0;
    int   checks = 0;
    int   busy_cycles = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .in_clock(clk), .in_reset(rst), .in_write(wr8), .in_data(d8), .in_enable(en),
        .out_bit(bit8), .out_busy(busy8), .out_full(full8), .out_last(last8),
        .out_overflow(ovf8)
    );

    piso_serializer #(.WIDTH(12), .MSB_FIRST(1'b0)) dut12 (
        .in_clock(clk), .in_reset(rst), .in_write(wr12), .in_data(d12), .in_enable(en),
        .out_bit(bit12), .out_busy(busy12), .out_full(full12), .out_last(last12),
        .out_overflow(ovf12)
    );

    task automatic push_word(input logic [11:0] d, input int w, input bit msb);
        exp_t x;
        for (int i = 0; i < w; i++) begin
            x.b = msb ? d[w-1-i] : d[i];
            x.l = (i == w - 1);
            sbq.push_back(x);
        end
    endtask

    // Checks the bit on the line before the edge that consumes it, then drives and clocks.
    task automatic step(input logic wr, input logic [11:0] d, input logic e, input bit sel12);
        logic ob, obusy, olast;
        exp_t x;
        ob    = sel12 ? bit12 : bit8;
        obusy = sel12 ? busy12 : busy8;
        olast = sel12 ? last12 : last8;
        if (obusy) busy_cycles++;
        if (obusy && e && !rst) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL extra_bit: got bit=%0b last=%0b, required no bit", ob, olast);
            end else begin
                x = sbq.pop_front();
                if ({ob, olast} !== {x.b, x.l}) begin
                    errors++;
                    $display("FAIL serial_bit: got bit=%0b last=%0b, required bit=%0b last=%0b",
                             ob, olast, x.b, x.l);
                end
            end
        end else if (!obusy) begin
            checks++;
            if (ob !== 1'b0 || olast !== 1'b0) begin
                errors++;
                $display("FAIL idle_out: got bit=%0b last=%0b, required 0 0", ob, olast);
            end
        end
        wr8  = wr && !sel12;
        wr12 = wr && sel12;
        d8   = d[7:0];
        d12  = d;
        en   = e;
        @(posedge clk);
        #1;
        wr8  = 1'b0;
        wr12 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr8 = 1'b0; wr12 = 1'b0; en = 1'b0; d8 = '0; d12 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bit8, busy8, full8, last8, ovf8, bit12, busy12, full12, last12, ovf12} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b, required 00000/00000",
                     {bit8, busy8, full8, last8, ovf8}, {bit12, busy12, full12, last12, ovf12});
        end
    endtask

    task automatic test_single_word();
        push_word(12'h0AA, 8, 1'b1);
        step(1'b1, 12'h0AA, 1'b1, 1'b0);
        checks++;
        if (full8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got full=%0b busy=%0b, required 1 0", full8, busy8);
        end
        step(1'b0, 12'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 12'h0, 1'b1, 1'b0);
        checks++;
        if (busy8 !== 1'b0 || bit8 !== 1'b0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL single_end: got busy=%0b bit=%0b left=%0d, required 0 0 0",
                     busy8, bit8, sbq.size());
        end
    endtask

    task automatic test_back_to_back();
        push_word(12'h0AA, 8, 1'b1);
        push_word(12'h0B5, 8, 1'b1);
        step(1'b1, 12'h0AA, 1'b1, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        step(1'b1, 12'h0B5, 1'b1, 1'b0);
        checks++;
        if (full8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full_set: got full=%0b, required 1", full8);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (busy8 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap: got busy=%0b at bit %0d, required 1", busy8, i + 1);
            end
            step(1'b0, 12'h0, 1'b1, 1'b0);
        end
        checks++;
        if (full8 !== 1'b0 || ovf8 !== 1'b0 || busy8 !== 1'b0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL b2b_end: got full=%0b ovf=%0b busy=%0b left=%0d, required 0 0 0 0",
                     full8, ovf8, busy8, sbq.size());
        end
    endtask

    task automatic test_enable_stall();
        push_word(12'h00F, 8, 1'b1);
        busy_cycles = 0;
        step(1'b1, 12'h00F, 1'b1, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bit8 !== 1'b0 || busy8 !== 1'b1) begin
                errors++;
                $display("FAIL stall_frozen: got bit=%0b busy=%0b, required 0 1", bit8, busy8);
            end
            step(1'b0, 12'h0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 12'h0, 1'b1, 1'b0);
        checks++;
        if (busy_cycles != 11 || sbq.size() != 0) begin
            errors++;
            $display("FAIL stall_span: got %0d cycles left=%0d, required 11 0",
                     busy_cycles, sbq.size());
        end
    endtask

    task automatic test_overflow();
        push_word(12'h011, 8, 1'b1);
        push_word(12'h022, 8, 1'b1);
        step(1'b1, 12'h011, 1'b0, 1'b0);
        step(1'b1, 12'h022, 1'b0, 1'b0);
        step(1'b1, 12'h033, 1'b0, 1'b0);
        checks++;
        if (ovf8 !== 1'b1 || full8 !== 1'b1 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%0b full=%0b busy=%0b, required 1 1 1",
                     ovf8, full8, busy8);
        end
        for (int i = 0; i < 40 && sbq.size() != 0; i++) step(1'b0, 12'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 12'h0, 1'b1, 1'b0);
        checks++;
        if (sbq.size() != 0 || ovf8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_end: got left=%0d ovf=%0b busy=%0b, required 0 1 0",
                     sbq.size(), ovf8, busy8);
        end
    endtask

    task automatic test_lsb_first();
        push_word(12'hA5C, 12, 1'b0);
        step(1'b1, 12'hA5C, 1'b1, 1'b1);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) step(1'b0, 12'h0, 1'b1, 1'b1);
        step(1'b0, 12'h0, 1'b1, 1'b1);
        checks++;
        if (sbq.size() != 0 || busy12 !== 1'b0 || ovf12 !== 1'b0) begin
            errors++;
            $display("FAIL lsb_end: got left=%0d busy=%0b ovf=%0b, required 0 0 0",
                     sbq.size(), busy12, ovf12);
        end
    endtask

    task automatic test_reset_midword();
        push_word(12'h0FF, 8, 1'b1);
        step(1'b1, 12'h0FF, 1'b1, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        step(1'b1, 12'h081, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b0, 12'h0, 1'b0, 1'b0);
        rst = 1'b0;
        sbq.delete();
        checks++;
        if ({bit8, busy8, full8, last8, ovf8} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, required 00000",
                     {bit8, busy8, full8, last8, ovf8});
        end
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 12'h0, 1'b1, 1'b0);
        checks++;
        if (busy_cycles != 0) begin
            errors++;
            $display("FAIL midreset_silent: got %0d busy cycles, required 0", busy_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_enable_stall();
        test_overflow();
        test_lsb_first();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out serializer. It is the successor to the team's fixed 8-bit serializer and adds:
- configurable word width and bit order;
- a one-word holding buffer, so words stream back-to-back with no gap;
- busy, full, last-bit and overflow status outputs.
It sits between a parallel word producer and a bit-serial link whose bit rate is set by an external enable strobe.

Parameters:
WIDTH, 8, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
in_clock  input  1  single clock; all state updates on rising edge.
in_reset  input  1  synchronous, active-high reset.
in_write  input  1  write strobe; in_data is sampled on an edge where it is high.
in_data  input  WIDTH  parallel word to transmit.
in_enable  input  1  bit-rate strobe; the shifter advances one bit per edge with in_enable=1.
out_bit  output  1  serial data; 0 when idle.
out_busy  output  1  shifter holds a word in progress.
out_full  output  1  holding buffer occupied; a write now is dropped unless the buffer drains in the same cycle.
out_last  output  1  out_bit currently carries the final bit of the word.
out_overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Storage: holding register hold (WIDTH) plus hold_valid; shift register sh (WIDTH); bit counter cnt ($clog2(WIDTH) bits); FSM states IDLE and SHIFT.
- Reset: when in_reset=1 at an edge:
  - state=IDLE, hold_valid=0, sh=0, cnt=0, out_overflow=0;
  - outputs after that edge: out_bit=0, out_busy=0, out_full=0, out_last=0;
  - reset mid-word discards both the word being shifted and the buffered word;
  - reset has priority over all other inputs.
- Combinational outputs:
  - out_busy = (state==SHIFT).
  - out_full = hold_valid.
  - out_bit = SHIFT ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : 0.
  - out_last = SHIFT && cnt==WIDTH-1.
- drain: asserted when hold_valid && (state==IDLE || (state==SHIFT && in_enable && cnt==WIDTH-1)).
- Write acceptance:
  - in_write is accepted if !hold_valid || drain. On acceptance, hold<=in_data and hold_valid<=1.
  - Otherwise the word is dropped, out_overflow<=1, and hold is unchanged.
- On drain: sh<=hold, cnt<=0, state<=SHIFT. hold_valid<=0 unless a write is accepted on the same edge.
- IDLE:
  - loads from hold whenever hold_valid=1, regardless of in_enable;
  - otherwise stays in IDLE.
- SHIFT, in_enable=0: everything frozen; out_bit holds its value.
- SHIFT, in_enable=1, cnt<WIDTH-1: shift sh by one toward the output end, fill with 0, cnt<=cnt+1.
- SHIFT, in_enable=1, cnt==WIDTH-1: word complete.
  - If hold_valid, drain (next word starts with no idle cycle).
  - Else state<=IDLE.
- Latency: in_write high at edge k into an idle, empty block gives:
  - hold_valid=1 after edge k;
  - first data bit on out_bit after edge k+1;
  - each bit then lasts until the next edge with in_enable=1.
- Throughput: one word per WIDTH enabled cycles, sustained, provided each next word is written before the current word's last enabled cycle.
- Simultaneous write and drain on the same edge: the new word is accepted into hold and the old word moves to sh.
- out_overflow clears only on reset.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, in_enable held 1; write 0xAA once. Required: out_bit = 1,0,1,0,1,0,1,0 on 8 consecutive cycles starting the cycle after the write edge+1; out_last=1 only on the 8th; then out_busy=0 and out_bit=0.
2. Write 0xAA, then write 0xB5 while 0xAA is shifting. Required: 16 contiguous bits 10101010 10110101 with no idle gap; out_full falls when 0xB5 loads; out_overflow=0.
3. Mid-word, drop in_enable for 3 cycles after bit 3 of 0x0F. Required: out_bit frozen at 0 for those cycles; remaining bits 1,1,1,1 follow once in_enable returns; the word spans 11 cycles in total.
4. With in_enable=0, write 0x11, 0x22, 0x33 on consecutive edges. Required: 0x11 goes to the shifter and 0x22 to hold; 0x33 is dropped and out_overflow=1 from then on; output sequence is 0x11 then 0x22 only.
5. WIDTH=12, MSB_FIRST=0, write 0xA5C. Required: out_bit = 0,0,1,1,1,0,1,0,0,1,0,1 (LSB first); out_last on the 12th bit.
6. Assert in_reset at bit 4 of 0xFF while 0x81 is in hold. Required: all outputs 0 the cycle after the reset edge; out_overflow cleared; no further bits emitted until a new write.
